// File: rtl/ip_arp_cache.sv
//------------------------------------------------------------------------------
// Module   : ip_arp_cache
// Brief    : Small fully-associative IP-to-MAC cache with next-hop resolution,
//            broadcast detection and round-robin replacement.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ip_arp_cache #(
  parameter int CACHE_ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        query_request_valid,
  output logic        query_request_ready,
  input  logic [31:0] query_request_ip,
  output logic        query_response_valid,
  input  logic        query_response_ready,
  output logic        query_response_error,
  output logic [47:0] query_response_mac,

  input  logic        write_request_valid,
  output logic        write_request_ready,
  input  logic [31:0] write_request_ip,
  input  logic [47:0] write_request_mac,

  input  logic        clear_cache,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask
);

  localparam int c_ENTRIES = 1 << CACHE_ADDR_WIDTH;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_LOOKUP  = 2'd1;
  localparam logic [1:0] c_ST_RESPOND = 2'd2;

  localparam logic [31:0] c_IP_ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [47:0] c_MAC_BCAST    = 48'hFFFF_FFFF_FFFF;

  logic [1:0]                  r_state;
  logic [31:0]                 r_resolved_ip;
  logic                        r_bcast;
  logic [47:0]                 r_resp_mac;
  logic                        r_resp_err;

  logic [c_ENTRIES-1:0]        r_valid;
  logic [CACHE_ADDR_WIDTH-1:0] r_ptr;
  logic [31:0]                 r_ip  [c_ENTRIES];
  logic [47:0]                 r_mac [c_ENTRIES];

  logic                        w_req_fire;
  logic                        w_on_subnet;
  logic                        w_bcast;
  logic [31:0]                 w_next_hop;

  logic [c_ENTRIES-1:0]        w_lu_match;
  logic                        w_lu_hit;
  logic [47:0]                 w_lu_mac;

  logic [c_ENTRIES-1:0]        w_wr_match;
  logic                        w_wr_hit;
  logic [CACHE_ADDR_WIDTH-1:0] w_wr_idx;
  logic                        w_wr_do;

  // Handshake signals
  assign query_request_ready  = (r_state == c_ST_IDLE) & ~rst;
  assign query_response_valid = (r_state == c_ST_RESPOND);
  assign query_response_mac   = r_resp_mac;
  assign query_response_error = r_resp_err;
  assign write_request_ready  = ~clear_cache;

  assign w_req_fire = query_request_valid & query_request_ready;

  // Next-hop resolution from the configuration seen at acceptance time
  assign w_on_subnet = ((query_request_ip & subnet_mask) == (local_ip & subnet_mask));
  assign w_next_hop  = w_on_subnet ? query_request_ip : gateway_ip;
  assign w_bcast     = (query_request_ip == c_IP_ALL_ONES) |
                       (((query_request_ip | subnet_mask) == c_IP_ALL_ONES) & w_on_subnet);

  generate
    for (genvar g = 0; g < c_ENTRIES; g++) begin : g_match
      assign w_lu_match[g] = r_valid[g] & (r_ip[g] == r_resolved_ip);
      assign w_wr_match[g] = r_valid[g] & (r_ip[g] == write_request_ip);
    end
  endgenerate

  // Descending scan so the lowest matching index wins
  always_comb begin
    w_lu_hit = 1'b0;
    w_lu_mac = '0;
    w_wr_hit = 1'b0;
    w_wr_idx = '0;
    for (int i = c_ENTRIES - 1; i >= 0; i--) begin
      if (w_lu_match[i]) begin
        w_lu_hit = 1'b1;
        w_lu_mac = r_mac[i];
      end
      if (w_wr_match[i]) begin
        w_wr_hit = 1'b1;
        w_wr_idx = CACHE_ADDR_WIDTH'(i);
      end
    end
  end

  assign w_wr_do = write_request_valid & write_request_ready & (write_request_ip != 32'd0);

  // Query FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_IDLE;
      r_resolved_ip <= '0;
      r_bcast       <= 1'b0;
      r_resp_mac    <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_req_fire) begin
            r_resolved_ip <= w_next_hop;
            r_bcast       <= w_bcast;
            r_state       <= c_ST_LOOKUP;
          end
        end
        c_ST_LOOKUP: begin
          if (r_bcast) begin
            r_resp_mac <= c_MAC_BCAST;
            r_resp_err <= 1'b0;
          end else if (w_lu_hit) begin
            r_resp_mac <= w_lu_mac;
            r_resp_err <= 1'b0;
          end else begin
            r_resp_mac <= '0;
            r_resp_err <= 1'b1;
          end
          r_state <= c_ST_RESPOND;
        end
        c_ST_RESPOND: begin
          if (query_response_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Valid bits and replacement pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (clear_cache) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_wr_do && !w_wr_hit) begin
      r_valid[r_ptr] <= 1'b1;
      r_ptr          <= r_ptr + CACHE_ADDR_WIDTH'(1);
    end
  end

  // Table storage carries no reset; the valid bits gate every read
  always_ff @(posedge clk) begin
    if (w_wr_do) begin
      if (w_wr_hit) begin
        r_mac[w_wr_idx] <= write_request_mac;
      end else begin
        r_ip[r_ptr]  <= write_request_ip;
        r_mac[r_ptr] <= write_request_mac;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ip_arp_cache.sv
//------------------------------------------------------------------------------
// Module   : tb_ip_arp_cache
// Brief    : Directed self-checking bench for ip_arp_cache.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ip_arp_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qv = 1'b0;
  logic        qrdy;
  logic [31:0] qip = '0;
  logic        rv;
  logic        rrdy = 1'b0;
  logic        rerr;
  logic [47:0] rmac;
  logic        wv = 1'b0;
  logic        wrdy;
  logic [31:0] wip = '0;
  logic [47:0] wmac = '0;
  logic        clr = 1'b0;
  logic [31:0] lip = 32'hC0A8_0180;
  logic [31:0] gip = 32'hC0A8_0101;
  logic [31:0] msk = 32'hFFFF_FF00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ip_arp_cache #(.CACHE_ADDR_WIDTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .query_request_valid  (qv),
    .query_request_ready  (qrdy),
    .query_request_ip     (qip),
    .query_response_valid (rv),
    .query_response_ready (rrdy),
    .query_response_error (rerr),
    .query_response_mac   (rmac),
    .write_request_valid  (wv),
    .write_request_ready  (wrdy),
    .write_request_ip     (wip),
    .write_request_mac    (wmac),
    .clear_cache          (clr),
    .local_ip             (lip),
    .gateway_ip           (gip),
    .subnet_mask          (msk)
  );

  task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
    @(negedge clk);
    wv = 1'b1; wip = ip; wmac = mac;
    @(posedge clk); #1;
    wv = 1'b0;
  endtask

  // Full query transaction; lat counts negedges from acceptance to valid
  task automatic do_query(input logic [31:0] ip, output logic [47:0] mac,
                          output logic err, output int lat);
    int n;
    @(negedge clk);
    qv = 1'b1; qip = ip;
    n = 0;
    while (!qrdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    qv = 1'b0;
    lat = 0;
    mac = '0; err = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rv) break;
    end
    if (!rv) lat = 99;
    mac = rmac; err = rerr;
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (qrdy !== 1'b0) begin fails++; $display("FAIL reset_qrdy got %b want 0", qrdy); end
    tests++;
    if (rv !== 1'b0 || rerr !== 1'b0 || rmac !== 48'd0) begin
      fails++; $display("FAIL reset_outputs got v=%b e=%b mac=%h want 0/0/0", rv, rerr, rmac);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (qrdy !== 1'b1 || wrdy !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready got q=%b w=%b want 1/1", qrdy, wrdy);
    end
  endtask

  task automatic test_hit();
    logic [47:0] m; logic e; int l;
    do_write(32'hC0A8_0166, 48'h5A51_5253_5455);
    do_query(32'hC0A8_0166, m, e, l);
    tests++;
    if (l !== 2) begin fails++; $display("FAIL hit_latency got %0d want 2", l); end
    tests++;
    if (m !== 48'h5A51_5253_5455 || e !== 1'b0) begin
      fails++; $display("FAIL hit_mac got %h err=%b want 5a5152535455 err=0", m, e);
    end
  endtask

  task automatic test_offsubnet();
    logic [47:0] m; logic e; int l;
    do_query(32'h0808_0808, m, e, l);
    tests++;
    if (m !== 48'd0 || e !== 1'b1) begin
      fails++; $display("FAIL gw_uncached got %h err=%b want 0 err=1", m, e);
    end
    do_write(32'hC0A8_0101, 48'h0011_2233_4455);
    do_query(32'h0808_0808, m, e, l);
    tests++;
    if (m !== 48'h0011_2233_4455 || e !== 1'b0) begin
      fails++; $display("FAIL gw_cached got %h err=%b want 001122334455 err=0", m, e);
    end
  endtask

  task automatic test_broadcast();
    logic [47:0] m; logic e; int l;
    do_clear();
    do_query(32'hFFFF_FFFF, m, e, l);
    tests++;
    if (m !== 48'hFFFF_FFFF_FFFF || e !== 1'b0) begin
      fails++; $display("FAIL bcast_all got %h err=%b want ffffffffffff err=0", m, e);
    end
    do_query(32'hC0A8_01FF, m, e, l);
    tests++;
    if (m !== 48'hFFFF_FFFF_FFFF || e !== 1'b0) begin
      fails++; $display("FAIL bcast_subnet got %h err=%b want ffffffffffff err=0", m, e);
    end
  endtask

  task automatic test_replacement();
    logic [47:0] m; logic e; int l;
    do_clear();
    for (int i = 0; i < 5; i++)
      do_write(32'hC0A8_010A + i, 48'hA0_0000_0000 + i);
    do_query(32'hC0A8_010A, m, e, l);
    tests++;
    if (e !== 1'b1 || m !== 48'd0) begin
      fails++; $display("FAIL repl_first_evicted got %h err=%b want 0 err=1", m, e);
    end
    for (int i = 1; i < 5; i++) begin
      do_query(32'hC0A8_010A + i, m, e, l);
      tests++;
      if (e !== 1'b0 || m !== 48'hA0_0000_0000 + i) begin
        fails++; $display("FAIL repl_hit%0d got %h err=%b want %h err=0", i, m, e, 48'hA0_0000_0000 + i);
      end
    end
    // Update in place of IP 3, then one new IP: it must evict IP 2, not IP 3
    do_write(32'hC0A8_010C, 48'hBEEF_0000_0003);
    do_write(32'hC0A8_010F, 48'hA0_0000_0005);
    do_write(32'h0000_0000, 48'hDEAD_DEAD_DEAD);
    do_query(32'hC0A8_010C, m, e, l);
    tests++;
    if (e !== 1'b0 || m !== 48'hBEEF_0000_0003) begin
      fails++; $display("FAIL repl_update got %h err=%b want beef00000003 err=0", m, e);
    end
    do_query(32'hC0A8_010B, m, e, l);
    tests++;
    if (e !== 1'b1) begin fails++; $display("FAIL repl_ptr_unchanged got err=%b want 1", e); end
    do_query(32'hC0A8_010F, m, e, l);
    tests++;
    if (e !== 1'b0 || m !== 48'hA0_0000_0005) begin
      fails++; $display("FAIL repl_new got %h err=%b want a00000000005 err=0", m, e);
    end
    do_query(32'hC0A8_010D, m, e, l);
    tests++;
    if (e !== 1'b0 || m !== 48'hA0_0000_0003) begin
      fails++; $display("FAIL repl_keep got %h err=%b want a00000000003 err=0", m, e);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] m; int bad; int n;
    do_write(32'hC0A8_0166, 48'h5A51_5253_5455);
    @(negedge clk);
    qv = 1'b1; qip = 32'hC0A8_0166;
    @(posedge clk); #1;
    qv = 1'b0;
    lip = 32'h0A00_0001;
    gip = 32'h0A00_00FE;
    n = 0;
    while (!rv && n < 10) begin @(negedge clk); n++; end
    m = rmac;
    tests++;
    if (rv !== 1'b1 || m !== 48'h5A51_5253_5455) begin
      fails++; $display("FAIL bp_first got v=%b mac=%h want 1 5a5152535455", rv, m);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv !== 1'b1 || rmac !== m || qrdy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    rrdy = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b0;
    lip = 32'hC0A8_0180;
    gip = 32'hC0A8_0101;
    @(negedge clk);
    tests++;
    if (qrdy !== 1'b1 || rv !== 1'b0) begin
      fails++; $display("FAIL back_to_back got qrdy=%b v=%b want 1/0", qrdy, rv);
    end
  endtask

  task automatic test_clear();
    logic [47:0] m; logic e; int l;
    @(negedge clk);
    clr = 1'b1;
    wv = 1'b1; wip = 32'hC0A8_0132; wmac = 48'h1234_5678_9ABC;
    #1;
    tests++;
    if (wrdy !== 1'b0) begin fails++; $display("FAIL clear_wrdy got %b want 0", wrdy); end
    @(posedge clk); #1;
    clr = 1'b0; wv = 1'b0;
    do_query(32'hC0A8_0166, m, e, l);
    tests++;
    if (e !== 1'b1 || m !== 48'd0) begin
      fails++; $display("FAIL clear_miss got %h err=%b want 0 err=1", m, e);
    end
    do_query(32'hC0A8_0132, m, e, l);
    tests++;
    if (e !== 1'b1) begin fails++; $display("FAIL clear_priority got err=%b want 1", e); end
  endtask

  task automatic test_reset_midquery();
    logic [47:0] m; logic e; int l; int seen;
    do_write(32'hC0A8_0166, 48'h5A51_5253_5455);
    @(negedge clk);
    qv = 1'b1; qip = 32'hC0A8_0166;
    @(posedge clk); #2;
    qv = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (rv !== 1'b0 || rmac !== 48'd0 || rerr !== 1'b0 || qrdy !== 1'b0) begin
      fails++; $display("FAIL rst_async got v=%b mac=%h e=%b q=%b want all 0", rv, rmac, rerr, qrdy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_resp got %0d valid cycles want 0", seen); end
    do_query(32'hC0A8_0166, m, e, l);
    tests++;
    if (e !== 1'b1 || m !== 48'd0) begin
      fails++; $display("FAIL rst_cache_empty got %h err=%b want 0 err=1", m, e);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_offsubnet();
    test_broadcast();
    test_replacement();
    test_backpressure();
    test_clear();
    test_reset_midquery();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
